// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, defaults and requester-select encodings for the writeback port arbiter.
package wb_port_arbiter_pkg;
  localparam int WB_REG_WIDTH  = 16;
  localparam int WB_NUM_REGS   = 16;
  localparam int WB_IDX_WIDTH  = 4;
  localparam int WB_STARVE_MAX = 3;

  typedef enum logic [1:0] {
    WB_SEL_NONE = 2'd0,
    WB_SEL_ALU  = 2'd1,
    WB_SEL_MEM  = 2'd2
  } wb_sel_e;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Requester, decode and write-port signals of the writeback arbiter.
// Bypass outputs exist only when WB_BYPASS_EN is defined.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;
  logic                    I_LOCK;
  logic                    I_AluValid;
  logic [WB_IDX_WIDTH-1:0] I_AluIdx;
  logic [WB_REG_WIDTH-1:0] I_AluData;
  logic                    O_AluReady;
  logic                    I_MemValid;
  logic [WB_IDX_WIDTH-1:0] I_MemIdx;
  logic [WB_REG_WIDTH-1:0] I_MemData;
  logic                    O_MemReady;
  logic                    I_IssueValid;
  logic [WB_IDX_WIDTH-1:0] I_IssueIdx;
  logic                    I_SrcUse1;
  logic [WB_IDX_WIDTH-1:0] I_SrcIdx1;
  logic                    I_SrcUse2;
  logic [WB_IDX_WIDTH-1:0] I_SrcIdx2;
  logic                    O_DepStall;
  logic                    O_WriteBackEnable;
  logic [WB_IDX_WIDTH-1:0] O_WriteBackRegIdx;
  logic [WB_REG_WIDTH-1:0] O_WriteBackData;
  logic [WB_NUM_REGS-1:0]  O_Pending;
`ifdef WB_BYPASS_EN
  logic                    O_BypassHit1;
  logic                    O_BypassHit2;
  logic [WB_REG_WIDTH-1:0] O_BypassData;
`endif

  modport slave (
    input  I_LOCK, I_AluValid, I_AluIdx, I_AluData, I_MemValid, I_MemIdx, I_MemData,
           I_IssueValid, I_IssueIdx, I_SrcUse1, I_SrcIdx1, I_SrcUse2, I_SrcIdx2,
    output O_AluReady, O_MemReady, O_DepStall, O_WriteBackEnable, O_WriteBackRegIdx,
           O_WriteBackData, O_Pending
`ifdef WB_BYPASS_EN
  , output O_BypassHit1, O_BypassHit2, O_BypassData
`endif
  );

  modport master (
    output I_LOCK, I_AluValid, I_AluIdx, I_AluData, I_MemValid, I_MemIdx, I_MemData,
           I_IssueValid, I_IssueIdx, I_SrcUse1, I_SrcIdx1, I_SrcUse2, I_SrcIdx2,
    input  O_AluReady, O_MemReady, O_DepStall, O_WriteBackEnable, O_WriteBackRegIdx,
           O_WriteBackData, O_Pending
`ifdef WB_BYPASS_EN
  , input  O_BypassHit1, O_BypassHit2, O_BypassData
`endif
  );
endinterface

// File: rtl/wb_port_arbiter_scoreboard.sv
// Pending-write scoreboard and decode dependency stall (RAW and WAW).
// WB_BYPASS_EN: sources matching the committing register do not stall.
module wb_port_arbiter_scoreboard
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_REGS = WB_NUM_REGS
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_lock,
  input  logic                    i_issue_valid,
  input  logic [WB_IDX_WIDTH-1:0] i_issue_idx,
  input  logic                    i_src_use1,
  input  logic [WB_IDX_WIDTH-1:0] i_src_idx1,
  input  logic                    i_src_use2,
  input  logic [WB_IDX_WIDTH-1:0] i_src_idx2,
  input  logic                    i_wb_en,
  input  logic [WB_IDX_WIDTH-1:0] i_wb_idx,
`ifdef WB_BYPASS_EN
  output logic                    o_bypass_hit1,
  output logic                    o_bypass_hit2,
`endif
  output logic [NUM_REGS-1:0]     o_pending,
  output logic                    o_dep_stall
);
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_nxt;
  logic                w_src1_raw;
  logic                w_src2_raw;
  logic                w_waw;
  logic                w_set;

`ifdef WB_BYPASS_EN
  assign o_bypass_hit1 = i_src_use1 & i_wb_en & (i_wb_idx == i_src_idx1);
  assign o_bypass_hit2 = i_src_use2 & i_wb_en & (i_wb_idx == i_src_idx2);
  assign w_src1_raw    = i_src_use1 & r_pending[i_src_idx1] & ~o_bypass_hit1;
  assign w_src2_raw    = i_src_use2 & r_pending[i_src_idx2] & ~o_bypass_hit2;
`else
  assign w_src1_raw    = i_src_use1 & r_pending[i_src_idx1];
  assign w_src2_raw    = i_src_use2 & r_pending[i_src_idx2];
`endif
  // WAW is never bypassed: the older write must retire before a new owner is recorded.
  assign w_waw       = i_issue_valid & r_pending[i_issue_idx];
  assign o_dep_stall = i_lock & (w_src1_raw | w_src2_raw | w_waw);
  assign w_set       = i_issue_valid & ~o_dep_stall & i_lock;
  assign o_pending   = r_pending;

  // Clear first, then set, so a same-cycle issue of the committing register stays pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_wb_en) w_pending_nxt[i_wb_idx] = 1'b0;
    if (w_set)   w_pending_nxt[i_issue_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pending <= '0;
    else          r_pending <= w_pending_nxt;
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: MEM-priority with ALU anti-starvation, registered write port,
// pending scoreboard. Optional feature macro: WB_BYPASS_EN (commit-cycle source bypass).
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int REG_WIDTH  = WB_REG_WIDTH,
  parameter int NUM_REGS   = WB_NUM_REGS,
  parameter int STARVE_MAX = WB_STARVE_MAX
) (
  input  logic              I_CLOCK,
  input  logic              I_RESET_N,
  wb_port_arbiter_if.slave  wb
);
  wb_sel_e                 w_sel;
  logic                    w_alu_force;
  logic [2:0]              r_starve;
  logic                    r_wb_en;
  logic [WB_IDX_WIDTH-1:0] r_wb_idx;
  logic [REG_WIDTH-1:0]    r_wb_data;

  assign w_alu_force = (r_starve == 3'(STARVE_MAX));

  // Readies are gated by reset so every output reads 0 while reset is asserted.
  always_comb begin
    w_sel = WB_SEL_NONE;
    if (I_RESET_N && wb.I_LOCK) begin
      if (wb.I_MemValid && !(wb.I_AluValid && w_alu_force)) w_sel = WB_SEL_MEM;
      else if (wb.I_AluValid)                                 w_sel = WB_SEL_ALU;
    end
  end

  assign wb.O_AluReady = (w_sel == WB_SEL_ALU);
  assign wb.O_MemReady = (w_sel == WB_SEL_MEM);

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_starve <= '0;
    end else if (wb.I_LOCK) begin
      if (!wb.I_AluValid || w_sel == WB_SEL_ALU)      r_starve <= '0;
      else if (w_sel == WB_SEL_MEM && !w_alu_force)   r_starve <= r_starve + 3'd1;
    end
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_wb_en   <= 1'b0;
      r_wb_idx  <= '0;
      r_wb_data <= '0;
    end else begin
      case (w_sel)
        WB_SEL_ALU: begin
          r_wb_en   <= 1'b1;
          r_wb_idx  <= wb.I_AluIdx;
          r_wb_data <= wb.I_AluData;
        end
        WB_SEL_MEM: begin
          r_wb_en   <= 1'b1;
          r_wb_idx  <= wb.I_MemIdx;
          r_wb_data <= wb.I_MemData;
        end
        default: begin
          r_wb_en   <= 1'b0;
          r_wb_idx  <= '0;
          r_wb_data <= '0;
        end
      endcase
    end
  end

  assign wb.O_WriteBackEnable = r_wb_en;
  assign wb.O_WriteBackRegIdx = r_wb_idx;
  assign wb.O_WriteBackData   = r_wb_data;
`ifdef WB_BYPASS_EN
  assign wb.O_BypassData      = r_wb_data;
`endif

  wb_port_arbiter_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .i_clk         (I_CLOCK),
    .i_rst_n       (I_RESET_N),
    .i_lock        (wb.I_LOCK),
    .i_issue_valid (wb.I_IssueValid),
    .i_issue_idx   (wb.I_IssueIdx),
    .i_src_use1    (wb.I_SrcUse1),
    .i_src_idx1    (wb.I_SrcIdx1),
    .i_src_use2    (wb.I_SrcUse2),
    .i_src_idx2    (wb.I_SrcIdx2),
    .i_wb_en       (r_wb_en),
    .i_wb_idx      (r_wb_idx),
`ifdef WB_BYPASS_EN
    .o_bypass_hit1 (wb.O_BypassHit1),
    .o_bypass_hit2 (wb.O_BypassHit2),
`endif
    .o_pending     (wb.O_Pending),
    .o_dep_stall   (wb.O_DepStall)
  );
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a behavioural model of arbitration,
// starvation, write latency and the pending scoreboard. Honours WB_BYPASS_EN.
module tb_wb_port_arbiter;
  localparam int SMAX = 3;

  logic clk;
  logic rst_n;
  wb_port_arbiter_if bus();

  wb_port_arbiter #(.REG_WIDTH(16), .NUM_REGS(16), .STARVE_MAX(SMAX)) dut (
    .I_CLOCK   (clk),
    .I_RESET_N (rst_n),
    .wb        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  bit        m_wb_en;
  bit [3:0]  m_wb_idx;
  bit [15:0] m_wb_data;
  bit [15:0] m_pend;
  int        m_starve;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wb_en = 0; m_wb_idx = 0; m_wb_data = 0; m_pend = 0; m_starve = 0;
  endtask

  task automatic clr_in();
    bus.I_LOCK = 1; bus.I_AluValid = 0; bus.I_AluIdx = 0; bus.I_AluData = 0;
    bus.I_MemValid = 0; bus.I_MemIdx = 0; bus.I_MemData = 0;
    bus.I_IssueValid = 0; bus.I_IssueIdx = 0;
    bus.I_SrcUse1 = 0; bus.I_SrcIdx1 = 0; bus.I_SrcUse2 = 0; bus.I_SrcIdx2 = 0;
  endtask

  // One clock: check every output against the model mid-cycle, then advance the model at the edge.
  task automatic cycle(input string tag);
    bit e_alu, e_mem, e_stall, b1, b2, waw, r1, r2, n_en;
    bit [3:0]  n_idx;
    bit [15:0] n_data, n_pend;
    int        n_starve;
    @(negedge clk);
    e_alu = 0; e_mem = 0;
    if (bus.I_LOCK) begin
      if (bus.I_MemValid && !(bus.I_AluValid && m_starve == SMAX)) e_mem = 1;
      else if (bus.I_AluValid) e_alu = 1;
    end
    b1 = bus.I_SrcUse1 && m_wb_en && (m_wb_idx == bus.I_SrcIdx1);
    b2 = bus.I_SrcUse2 && m_wb_en && (m_wb_idx == bus.I_SrcIdx2);
    r1 = bus.I_SrcUse1 && m_pend[bus.I_SrcIdx1];
    r2 = bus.I_SrcUse2 && m_pend[bus.I_SrcIdx2];
`ifdef WB_BYPASS_EN
    r1 = r1 && !b1;
    r2 = r2 && !b2;
    chk({tag, "_byp1"}, bus.O_BypassHit1, b1);
    chk({tag, "_byp2"}, bus.O_BypassHit2, b2);
    chk({tag, "_bypd"}, bus.O_BypassData, m_wb_data);
`endif
    waw = bus.I_IssueValid && m_pend[bus.I_IssueIdx];
    e_stall = bus.I_LOCK && (r1 || r2 || waw);
    chk({tag, "_alu_rdy"}, bus.O_AluReady, e_alu);
    chk({tag, "_mem_rdy"}, bus.O_MemReady, e_mem);
    chk({tag, "_stall"},   bus.O_DepStall, e_stall);
    chk({tag, "_wb_en"},   bus.O_WriteBackEnable, m_wb_en);
    chk({tag, "_wb_idx"},  bus.O_WriteBackRegIdx, m_wb_idx);
    chk({tag, "_wb_data"}, bus.O_WriteBackData, m_wb_data);
    chk({tag, "_pend"},    bus.O_Pending, m_pend);

    n_en = e_alu || e_mem;
    n_idx = e_alu ? bus.I_AluIdx : e_mem ? bus.I_MemIdx : 4'd0;
    n_data = e_alu ? bus.I_AluData : e_mem ? bus.I_MemData : 16'd0;
    n_starve = m_starve;
    if (bus.I_LOCK) begin
      if (!bus.I_AluValid || e_alu) n_starve = 0;
      else if (e_mem && m_starve < SMAX) n_starve = m_starve + 1;
    end
    n_pend = m_pend;
    if (m_wb_en) n_pend[m_wb_idx] = 0;
    if (bus.I_IssueValid && bus.I_LOCK && !e_stall) n_pend[bus.I_IssueIdx] = 1;
    @(posedge clk);
    #1;
    m_wb_en = n_en; m_wb_idx = n_idx; m_wb_data = n_data;
    m_pend = n_pend; m_starve = n_starve;
  endtask

  initial begin
    bit [15:0] saved;
    clr_in();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_en", bus.O_WriteBackEnable, 0);
    chk("rst_pend", bus.O_Pending, 0);
    rst_n = 1;

    // Test 1: build busy state, then assert reset mid-cycle.
    bus.I_IssueValid = 1; bus.I_IssueIdx = 4; cycle("t1a");
    bus.I_IssueIdx = 5; cycle("t1b");
    bus.I_IssueValid = 0; bus.I_AluValid = 1; bus.I_AluIdx = 9; bus.I_AluData = 16'hBEEF;
    cycle("t1c");
    chk("t1_pend30", bus.O_Pending, 16'h0030);
    chk("t1_wb_busy", bus.O_WriteBackEnable, 1);
    bus.I_MemValid = 1;
    #3 rst_n = 0;
    #1;
    chk("t1_async_en", bus.O_WriteBackEnable, 0);
    chk("t1_async_idx", bus.O_WriteBackRegIdx, 0);
    chk("t1_async_data", bus.O_WriteBackData, 0);
    chk("t1_async_pend", bus.O_Pending, 0);
    chk("t1_async_rdy", {bus.O_AluReady, bus.O_MemReady}, 0);
    chk("t1_async_stall", bus.O_DepStall, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    clr_in();

    // Test 2: both valid every cycle -> MEM,MEM,MEM,ALU repeating.
    bus.I_AluValid = 1; bus.I_AluIdx = 10; bus.I_AluData = 16'h0A0A;
    bus.I_MemValid = 1; bus.I_MemIdx = 11; bus.I_MemData = 16'h0B0B;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("t2_grant", {bus.O_AluReady, bus.O_MemReady}, (k % 4 == 3) ? 2'b10 : 2'b01);
      cycle("t2");
    end
    clr_in();
    cycle("t2d");

    // Test 3: RAW stall on R5 until its commit.
    bus.I_IssueValid = 1; bus.I_IssueIdx = 5; cycle("t3a");
    bus.I_IssueValid = 0; bus.I_SrcUse1 = 1; bus.I_SrcIdx1 = 5;
    #1 chk("t3_stall_raw", bus.O_DepStall, 1);
    cycle("t3b");
    bus.I_AluValid = 1; bus.I_AluIdx = 5; bus.I_AluData = 16'h1234;
    cycle("t3c");
    bus.I_AluValid = 0;
    #1;
    chk("t3_wb_idx", bus.O_WriteBackRegIdx, 5);
    chk("t3_wb_data", bus.O_WriteBackData, 16'h1234);
`ifdef WB_BYPASS_EN
    chk("t3_stall_commit", bus.O_DepStall, 0);
    chk("t3_bypass_data", bus.O_BypassData, 16'h1234);
`else
    chk("t3_stall_commit", bus.O_DepStall, 1);
`endif
    cycle("t3d");
    #1 chk("t3_stall_after", bus.O_DepStall, 0);
    cycle("t3e");
    clr_in();

    // Test 4: freeze with LOCK=0, then resume the starvation sequence.
    bus.I_IssueValid = 1; bus.I_IssueIdx = 2; cycle("t4a");
    bus.I_IssueValid = 0;
    bus.I_AluValid = 1; bus.I_AluIdx = 10; bus.I_AluData = 16'h1111;
    bus.I_MemValid = 1; bus.I_MemIdx = 9;  bus.I_MemData = 16'h2222;
    cycle("t4b");
    bus.I_LOCK = 0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t4_lock_rdy", {bus.O_AluReady, bus.O_MemReady}, 0);
      cycle("t4l");
    end
    chk("t4_frozen_pend", bus.O_Pending, 16'h0004);
    chk("t4_frozen_wb", bus.O_WriteBackEnable, 0);
    bus.I_LOCK = 1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t4_resume", {bus.O_AluReady, bus.O_MemReady}, (k == 2) ? 2'b10 : 2'b01);
      cycle("t4r");
    end
    clr_in();
    cycle("t4d");

    // Test 5: WAW stall on pending R3; same-cycle issue and commit of R7.
    bus.I_IssueValid = 1; bus.I_IssueIdx = 3; cycle("t5a");
    saved = bus.O_Pending;
    #1 chk("t5_waw_stall", bus.O_DepStall, 1);
    cycle("t5b");
    chk("t5_pend_same", bus.O_Pending, saved);
    bus.I_IssueValid = 0;
    bus.I_AluValid = 1; bus.I_AluIdx = 7; bus.I_AluData = 16'h7777;
    cycle("t5c");
    bus.I_AluValid = 0; bus.I_IssueValid = 1; bus.I_IssueIdx = 7;
    #1 chk("t5_no_stall", bus.O_DepStall, 0);
    cycle("t5d");
    chk("t5_pend7", bus.O_Pending[7], 1);
    clr_in();

    // Test 6: back-to-back MEM writes.
    bus.I_MemValid = 1; bus.I_MemIdx = 1; bus.I_MemData = 16'hAAAA; cycle("t6a");
    bus.I_MemIdx = 2; bus.I_MemData = 16'h5555;
    #1 chk("t6_wb1", {bus.O_WriteBackEnable, bus.O_WriteBackRegIdx, bus.O_WriteBackData}, {1'b1, 4'd1, 16'hAAAA});
    cycle("t6b");
    bus.I_MemValid = 0;
    #1 chk("t6_wb2", {bus.O_WriteBackEnable, bus.O_WriteBackRegIdx, bus.O_WriteBackData}, {1'b1, 4'd2, 16'h5555});
    cycle("t6c");
    chk("t6_idle", bus.O_WriteBackEnable, 0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      bus.I_LOCK       = ($urandom_range(0, 7) != 0);
      bus.I_AluValid   = $urandom_range(0, 1);
      bus.I_AluIdx     = 4'($urandom);
      bus.I_AluData    = 16'($urandom);
      bus.I_MemValid   = $urandom_range(0, 1);
      bus.I_MemIdx     = 4'($urandom);
      bus.I_MemData    = 16'($urandom);
      bus.I_IssueValid = ($urandom_range(0, 9) < 4);
      bus.I_IssueIdx   = 4'($urandom);
      bus.I_SrcUse1    = $urandom_range(0, 1);
      bus.I_SrcIdx1    = 4'($urandom);
      bus.I_SrcUse2    = $urandom_range(0, 1);
      bus.I_SrcIdx2    = 4'($urandom);
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
